// File: rtl/maxpool_ctrl_pkg.sv
// Shared constants, state encoding and width helper for the max-pooling window controller.
package maxpool_ctrl_pkg;

  localparam int DEF_DW = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACC   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  // Counter width for a range of n values, never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pool_acc.sv
// Running signed maximum register: loads on the first sample of a window, then keeps the larger value.
// Ties keep the stored value; updates only on accepted samples.
module pool_acc
  import maxpool_ctrl_pkg::*;
#(
  parameter int DW = DEF_DW
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_load,
  input  logic          i_en,
  input  logic [DW-1:0] i_data,
  output logic [DW-1:0] o_acc
);

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      o_acc <= '0;
    end else if (i_en && (i_load || ($signed(i_data) > $signed(o_acc)))) begin
      o_acc <= i_data;
    end
  end

endmodule

// File: rtl/maxpool_ctrl.sv
// Max-pool window sequencer: one pooled max per K*K samples, result valid the cycle after the closing sample.
// Only the closing sample of a window stalls, and only while the previous result is still unconsumed.
module maxpool_ctrl
  import maxpool_ctrl_pkg::*;
#(
  parameter int DW    = DEF_DW,
  parameter int K     = 2,
  parameter int OUT_W = 4,
  parameter int OUT_H = 4
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_start,
  input  logic [DW-1:0] i_data,
  input  logic          i_valid,
  output logic          o_ready,
  output logic [DW-1:0] o_data,
  output logic          o_valid,
  input  logic          i_ready,
  output logic          o_last,
  output logic          o_busy,
  output logic          o_done
);

  localparam int NS = K * K;
  localparam int SW = cnt_w(NS);
  localparam int XW = cnt_w(OUT_W);
  localparam int YW = cnt_w(OUT_H);

  localparam logic [SW-1:0] S_LAST = SW'(NS - 1);
  localparam logic [XW-1:0] X_LAST = XW'(OUT_W - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(OUT_H - 1);

  state_t        state_q, state_d;
  logic [SW-1:0] s_q;
  logic [XW-1:0] wx_q;
  logic [YW-1:0] wy_q;
  logic [DW-1:0] acc;
  logic [DW-1:0] win_max;
  logic [DW-1:0] data_q;
  logic          valid_q;
  logic          last_q;
  logic          done_q;
  logic          done_d;
  logic          accept;
  logic          consume;
  logic          closing;
  logic          s_is_last;
  logic          final_win;
  logic          start_go;

  assign s_is_last = (s_q == S_LAST);
  assign final_win = (wx_q == X_LAST) && (wy_q == Y_LAST);

  // i_ready reaches o_ready only through the closing-sample stall term.
  assign o_ready  = (state_q == ST_ACC) && !(s_is_last && valid_q && !i_ready);
  assign accept   = i_valid && o_ready;
  assign consume  = valid_q && i_ready;
  assign closing  = accept && s_is_last;
  // A start coinciding with the done pulse is ignored; restart is accepted one cycle later.
  assign start_go = i_start && !done_q;
  assign win_max  = ($signed(i_data) > $signed(acc)) ? i_data : acc;

  pool_acc #(
    .DW(DW)
  ) u_pool_acc (
    .i_clk  (i_clk),
    .i_rst_n(i_rst_n),
    .i_load (s_q == '0),
    .i_en   (accept),
    .i_data (i_data),
    .o_acc  (acc)
  );

  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start_go) state_d = ST_ACC;
      end
      ST_ACC: begin
        if (closing && final_win) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (!valid_q || consume) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      s_q  <= '0;
      wx_q <= '0;
      wy_q <= '0;
    end else if ((state_q == ST_IDLE) && start_go) begin
      s_q  <= '0;
      wx_q <= '0;
      wy_q <= '0;
    end else if (accept) begin
      if (s_is_last) begin
        s_q <= '0;
        if (wx_q == X_LAST) begin
          wx_q <= '0;
          wy_q <= (wy_q == Y_LAST) ? '0 : wy_q + YW'(1);
        end else begin
          wx_q <= wx_q + XW'(1);
        end
      end else begin
        s_q <= s_q + SW'(1);
      end
    end
  end

  // A closing sample reloads the slot even when the old result is consumed in the same cycle.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
    end else if (closing) begin
      data_q  <= win_max;
      valid_q <= 1'b1;
      last_q  <= final_win;
    end else if (consume) begin
      valid_q <= 1'b0;
      last_q  <= 1'b0;
    end
  end

  assign o_data  = data_q;
  assign o_valid = valid_q;
  assign o_last  = last_q;
  assign o_busy  = (state_q != ST_IDLE);
  assign o_done  = done_q;

endmodule

// File: tb/tb_maxpool_ctrl.sv
// Bench for maxpool_ctrl: directed and randomized frames checked against a per-window max model.
module tb_maxpool_ctrl;

  localparam int DW   = 16;
  localparam int K    = 2;
  localparam int OW   = 2;
  localparam int OH   = 2;
  localparam int N    = K * K;
  localparam int NWIN = OW * OH;
  localparam int TOT  = N * NWIN;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic [DW-1:0] din;
  logic          vin;
  logic          rdy;
  logic [DW-1:0] dout;
  logic          vout;
  logic          rin;
  logic          last;
  logic          busy;
  logic          done;

  int checks   = 0;
  int failures = 0;
  int smp[TOT];

  maxpool_ctrl #(
    .DW(DW), .K(K), .OUT_W(OW), .OUT_H(OH)
  ) dut (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .i_start(start),
    .i_data (din),
    .i_valid(vin),
    .o_ready(rdy),
    .o_data (dout),
    .o_valid(vout),
    .i_ready(rin),
    .o_last (last),
    .o_busy (busy),
    .o_done (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference: the pooled value of window w is simply the largest of its K*K samples.
  function automatic int win_max(input int w);
    int m;
    m = smp[w * N];
    for (int i = 1; i < N; i++) if (smp[w * N + i] > m) m = smp[w * N + i];
    return m;
  endfunction

  task automatic fill_random();
    for (int i = 0; i < TOT; i++) begin
      case ($urandom_range(3))
        0:       smp[i] = int'($signed(16'($urandom)));
        1:       smp[i] = int'($urandom_range(6)) - 3;
        2:       smp[i] = -1 - int'($urandom_range(32767));
        default: smp[i] = (i % 2 == 1) ? 32767 : -32768;
      endcase
    end
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    vin   = 1'b0;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic idle_outputs(input string tag);
    chk({tag, "_valid"}, vout, 0);
    chk({tag, "_ready"}, rdy, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_last"}, last, 0);
    chk({tag, "_data"}, $signed(dout), 0);
  endtask

  // Runs one frame from the cycle after start; every cycle compares all outputs to the model.
  task automatic run_frame(input string tag, input int vpct, input int rpct, input bit rand_start,
                           output int ncyc);
    int  sent, got, nclosed, c;
    bit  exp_valid, exp_rdy, acc, cons, done_due, fin;
    sent = 0; got = 0; nclosed = 0; done_due = 1'b0; fin = 1'b0;
    for (c = 0; c < 2000 && !fin; c++) begin
      vin   = ($urandom_range(99) < vpct);
      din   = (sent < TOT) ? DW'(smp[sent]) : DW'($urandom);
      rin   = ($urandom_range(99) < rpct);
      start = rand_start && !done_due && ($urandom_range(3) == 0);
      #1;
      exp_valid = (nclosed > got);
      exp_rdy   = (sent < TOT) && !((sent % N == N - 1) && exp_valid && !rin);
      chk({tag, "_valid"}, vout, exp_valid);
      if (exp_valid) begin
        chk({tag, "_data"}, $signed(dout), win_max(got));
        chk({tag, "_last"}, last, (got == NWIN - 1));
      end
      chk({tag, "_ready"}, rdy, exp_rdy);
      chk({tag, "_done"}, done, done_due);
      chk({tag, "_busy"}, busy, !done_due);
      if (done_due) begin
        fin = 1'b1;
      end else begin
        acc  = vin && exp_rdy;
        cons = exp_valid && rin;
        if (cons) got++;
        if (acc) begin
          sent++;
          if (sent % N == 0) nclosed++;
        end
        done_due = cons && (got == NWIN);
      end
      @(negedge clk);
    end
    ncyc  = c;
    start = 1'b0;
    vin   = 1'b0;
    if (!fin) chk({tag, "_timeout"}, 0, 1);
    chk({tag, "_post_done"}, done, 0);
    chk({tag, "_post_busy"}, busy, 0);
  endtask

  initial begin
    int ncyc;
    rst_n = 1'b0; start = 1'b0; vin = 1'b0; rin = 1'b0; din = '0;
    repeat (2) @(negedge clk);
    #1;
    idle_outputs("reset");
    rst_n = 1'b1;

    // Samples offered while idle must not be taken.
    @(negedge clk);
    vin = 1'b1; din = 16'sd32767; rin = 1'b1;
    #1;
    chk("idle_ready", rdy, 0);
    @(negedge clk);
    vin = 1'b0;

    // Directed frame: mixed, all-negative, tie and extreme windows at full rate.
    smp = '{3, -7, 9, 2, -5, -2, -9, -4, 4, 4, 4, 4, -32768, 32767, -1, 0};
    pulse_start();
    run_frame("f1", 100, 100, 1'b0, ncyc);
    chk("f1_cycles", ncyc, TOT + 2);

    // Restart right after done, with backpressure and starts while busy.
    fill_random();
    pulse_start();
    run_frame("f2", 100, 30, 1'b1, ncyc);

    // Mid-frame reset after six accepts, then a clean frame.
    fill_random();
    pulse_start();
    for (int i = 0; i < 6; i++) begin
      vin = 1'b1; rin = 1'b1; din = DW'(smp[i]);
      #1;
      chk("rst_pre_ready", rdy, 1);
      @(negedge clk);
    end
    rst_n = 1'b0; vin = 1'b0;
    @(negedge clk);
    #1;
    idle_outputs("midrst");
    rst_n = 1'b1;
    fill_random();
    pulse_start();
    run_frame("f3", 100, 100, 1'b0, ncyc);
    chk("f3_cycles", ncyc, TOT + 2);

    for (int f = 0; f < 6; f++) begin
      fill_random();
      pulse_start();
      run_frame($sformatf("r%0d", f), 40 + 12 * f, 100 - 14 * f, (f % 2 == 1), ncyc);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
